// File: rtl/sda_axi_lite_reg_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to register-bus bridge.
// Holds the AXI response codes and FSM state encodings used by the bridge.
package sda_axi_lite_reg_bridge_pkg;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = 4;
    localparam int unsigned RespWidth = 2;

    localparam logic [RespWidth-1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [RespWidth-1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WREQ  = 3'd1,
        ST_RREQ  = 3'd2,
        ST_WRESP = 3'd3,
        ST_RRESP = 3'd4
    } bridge_state_e;

    // Buffered AXI write-data beat.
    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
    } wbuf_t;

    // An acked access completes OKAY; an unacked (timed-out) one completes SLVERR.
    function automatic logic [RespWidth-1:0] resp_of(input logic acked);
        return acked ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    endfunction

endpackage

// File: rtl/sda_axi_lite_reg_bridge_timeout.sv
// REQ-phase watchdog for the register bridge; built only with SDA_REG_BRIDGE_TIMEOUT_EN.
// Counts REQ cycles and flags the cycle on which the access must be forced to complete.
`ifdef SDA_REG_BRIDGE_TIMEOUT_EN
module sda_reg_bridge_timeout #(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired_c
);

    localparam int unsigned RawWidth = $clog2(TimeoutCycles + 1);
    localparam int unsigned CntWidth = (RawWidth < 8) ? 8 : ((RawWidth > 16) ? 16 : RawWidth);
    localparam logic [CntWidth-1:0] LastCount = CntWidth'(TimeoutCycles - 1);

    logic [CntWidth-1:0] r_count;

    // Count value k marks the (k+1)-th REQ cycle, so expiry lands on cycle TimeoutCycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && !o_expired_c) begin
            r_count <= r_count + CntWidth'(1);
        end
    end

    assign o_expired_c = i_en && (r_count == LastCount);

endmodule
`endif

// File: rtl/sda_axi_lite_reg_bridge.sv
// AXI4-Lite slave to single-outstanding register bus initiator with OR-bus responders.
// Optional REQ timeout with SLVERR completion is enabled by SDA_REG_BRIDGE_TIMEOUT_EN.
module sda_axi_lite_reg_bridge
    import sda_axi_lite_reg_bridge_pkg::*;
#(
    parameter int unsigned AxiAddrWidth  = 12,
    parameter int unsigned RegAddrWidth  = 8,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [AxiAddrWidth-1:0] s_axi_awaddr,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    input  logic [DataWidth-1:0]    s_axi_wdata,
    input  logic [StrbWidth-1:0]    s_axi_wstrb,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [RespWidth-1:0]    s_axi_bresp,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    input  logic [AxiAddrWidth-1:0] s_axi_araddr,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [DataWidth-1:0]    s_axi_rdata,
    output logic [RespWidth-1:0]    s_axi_rresp,
    output logic                    regReq,
    input  logic                    regAck,
    output logic                    regWriteEn,
    output logic [RegAddrWidth-1:0] regAddr,
    output logic [DataWidth-1:0]    regWData,
    output logic [StrbWidth-1:0]    regWStrb,
    input  logic [DataWidth-1:0]    regRData
);

    localparam int unsigned WordAddrWidth = RegAddrWidth - 2;

    bridge_state_e              r_state;
    logic                       r_last_grant_rd;

    logic                       r_aw_full;
    logic                       r_w_full;
    logic                       r_ar_full;
    logic [WordAddrWidth-1:0]   r_aw_word;
    logic [WordAddrWidth-1:0]   r_ar_word;
    wbuf_t                      r_w_buf;
    logic                       r_awready;
    logic                       r_wready;
    logic                       r_arready;

    logic                       r_req;
    logic                       r_we;
    logic [RegAddrWidth-1:0]    r_addr;
    logic [DataWidth-1:0]       r_wdata;
    logic [StrbWidth-1:0]       r_wstrb;
    logic                       r_bvalid;
    logic [RespWidth-1:0]       r_bresp;
    logic                       r_rvalid;
    logic [RespWidth-1:0]       r_rresp;
    logic [DataWidth-1:0]       r_rdata;

    logic                       w_aw_hs;
    logic                       w_w_hs;
    logic                       w_ar_hs;
    logic                       w_wr_elig;
    logic                       w_rd_elig;
    logic                       w_grant_wr;
    logic                       w_grant_rd;
    logic                       w_in_req;
    logic                       w_expired;
    logic                       w_unused_ok;

    assign w_aw_hs = s_axi_awvalid & r_awready;
    assign w_w_hs  = s_axi_wvalid  & r_wready;
    assign w_ar_hs = s_axi_arvalid & r_arready;

    // Round-robin: on contention grant the opposite of the last grant.
    assign w_wr_elig  = r_aw_full & r_w_full;
    assign w_rd_elig  = r_ar_full;
    assign w_grant_rd = (r_state == ST_IDLE) & w_rd_elig & (~w_wr_elig | ~r_last_grant_rd);
    assign w_grant_wr = (r_state == ST_IDLE) & w_wr_elig & ~w_grant_rd;
    assign w_in_req   = (r_state == ST_WREQ) | (r_state == ST_RREQ);

`ifdef SDA_REG_BRIDGE_TIMEOUT_EN
    sda_reg_bridge_timeout #(
        .TimeoutCycles (TimeoutCycles)
    ) u_timeout (
        .clk         (clk),
        .rstn        (rstn),
        .i_clear     (w_grant_wr | w_grant_rd),
        .i_en        (w_in_req),
        .o_expired_c (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    // Address bits below the word and above the register window are dropped by design.
    assign w_unused_ok = ^{s_axi_awaddr, s_axi_araddr, 32'(TimeoutCycles)};

    // AW / W / AR skid buffers; each frees when its transaction is granted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_ar_full <= 1'b0;
            r_aw_word <= '0;
            r_ar_word <= '0;
            r_w_buf   <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_arready <= 1'b0;
        end else begin
            if (w_grant_wr) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_aw_full <= 1'b1;
                    r_aw_word <= s_axi_awaddr[RegAddrWidth-1:2];
                end
                if (w_w_hs) begin
                    r_w_full     <= 1'b1;
                    r_w_buf.data <= s_axi_wdata;
                    r_w_buf.strb <= s_axi_wstrb;
                end
            end
            if (w_grant_rd) begin
                r_ar_full <= 1'b0;
            end else if (w_ar_hs) begin
                r_ar_full <= 1'b1;
                r_ar_word <= s_axi_araddr[RegAddrWidth-1:2];
            end
            r_awready <= w_grant_wr | ~(w_aw_hs | r_aw_full);
            r_wready  <= w_grant_wr | ~(w_w_hs  | r_w_full);
            r_arready <= w_grant_rd | ~(w_ar_hs | r_ar_full);
        end
    end

    // Transaction FSM with registered bus and AXI response outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state         <= ST_IDLE;
            r_last_grant_rd <= 1'b0;
            r_req           <= 1'b0;
            r_we            <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_wstrb         <= '0;
            r_bvalid        <= 1'b0;
            r_bresp         <= AXI_RESP_OKAY;
            r_rvalid        <= 1'b0;
            r_rresp         <= AXI_RESP_OKAY;
            r_rdata         <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_rd) begin
                        r_state         <= ST_RREQ;
                        r_last_grant_rd <= 1'b1;
                        r_req           <= 1'b1;
                        r_we            <= 1'b0;
                        r_addr          <= {r_ar_word, 2'b00};
                        r_wdata         <= '0;
                        r_wstrb         <= '0;
                    end else if (w_grant_wr) begin
                        r_state         <= ST_WREQ;
                        r_last_grant_rd <= 1'b0;
                        r_req           <= 1'b1;
                        r_we            <= 1'b1;
                        r_addr          <= {r_aw_word, 2'b00};
                        r_wdata         <= r_w_buf.data;
                        r_wstrb         <= r_w_buf.strb;
                    end
                end
                ST_WREQ: begin
                    if (regAck || w_expired) begin
                        r_state  <= ST_WRESP;
                        r_req    <= 1'b0;
                        r_we     <= 1'b0;
                        r_addr   <= '0;
                        r_wdata  <= '0;
                        r_wstrb  <= '0;
                        r_bresp  <= resp_of(regAck);
                        r_bvalid <= 1'b1;
                    end
                end
                ST_RREQ: begin
                    if (regAck || w_expired) begin
                        r_state  <= ST_RRESP;
                        r_req    <= 1'b0;
                        r_we     <= 1'b0;
                        r_addr   <= '0;
                        r_wdata  <= '0;
                        r_wstrb  <= '0;
                        r_rresp  <= resp_of(regAck);
                        r_rdata  <= regAck ? regRData : '0;
                        r_rvalid <= 1'b1;
                    end
                end
                ST_WRESP: begin
                    if (s_axi_bready) begin
                        r_state  <= ST_IDLE;
                        r_bvalid <= 1'b0;
                    end
                end
                ST_RRESP: begin
                    if (s_axi_rready) begin
                        r_state  <= ST_IDLE;
                        r_rvalid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_arready = r_arready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;
    assign regReq        = r_req;
    assign regWriteEn    = r_we;
    assign regAddr       = r_addr;
    assign regWData      = r_wdata;
    assign regWStrb      = r_wstrb;

endmodule
